// File: rtl/timestamp_pkg.sv
// Shared definitions for the timestamp capture block: width helpers, default
// sizes and the legal parameter ranges.
package timestamp_pkg;

  localparam int TS_WIDTH_DEFAULT  = 24;
  localparam int TS_NUM_CH_DEFAULT = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits, even for a single channel.
  function automatic int ch_width(input int num_ch);
    return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
  endfunction

  function automatic bit params_ok(input int width, input int prescale,
                                   input int num_ch, input int saturate);
    return (width >= 2) && (width <= 48) && (prescale >= 1) &&
           (num_ch >= 1) && (num_ch <= 16) && ((saturate == 0) || (saturate == 1));
  endfunction

endpackage

// File: rtl/ts_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping around, so the last winner has the lowest priority next time.
module ts_rr_arbiter
  import timestamp_pkg::*;
#(
  parameter int NUM_CH = TS_NUM_CH_DEFAULT,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic              gnt_valid,
  output logic [CH_W-1:0]   gnt_idx
);

  logic [CH_W-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/timestamp_capture.sv
// Prescaled mission timestamp with preload and wrap/saturate, plus per-channel
// rising-edge capture delivered one at a time over a valid/ready port.
module timestamp_capture
  import timestamp_pkg::*;
#(
  parameter int WIDTH    = TS_WIDTH_DEFAULT,
  parameter int PRESCALE = 1,
  parameter int NUM_CH   = TS_NUM_CH_DEFAULT,
  parameter int SATURATE = 0,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VAL,
  output logic [WIDTH-1:0]  TIMESTAMP,
  output logic              TICK,
  output logic              ROLLOVER,
  output logic              SAT,
  input  logic [NUM_CH-1:0] EVENT,
  output logic              CAP_VALID,
  input  logic              CAP_READY,
  output logic [CH_W-1:0]   CAP_CH,
  output logic [WIDTH-1:0]  CAP_TS,
  output logic [NUM_CH-1:0] OVF,
  input  logic [NUM_CH-1:0] CLR_OVF
);

  localparam int PW = ch_width(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  if (!params_ok(WIDTH, PRESCALE, NUM_CH, SATURATE)) begin : g_param_check
    $error("timestamp_capture: parameter out of range");
  end

  logic [PW-1:0]    pre, pre_next;
  logic [WIDTH-1:0] ts_next;
  logic             tick_next, roll_next;

  // CAP port: a capture transfers on any edge where CAP_VALID and CAP_READY are
  // both high; CAP_CH/CAP_TS hold steady while CAP_VALID is high and not taken.
  logic [NUM_CH-1:0] event_d, edges, pend, move_hit;
  logic [WIDTH-1:0]  cap_mem [NUM_CH];
  logic [CH_W-1:0]   rr_ptr, win;
  logic              win_valid, move;

  always_comb begin
    ts_next   = TIMESTAMP;
    pre_next  = pre;
    tick_next = 1'b0;
    roll_next = 1'b0;
    if (LOAD) begin
      ts_next  = LOAD_VAL;
      pre_next = '0;
    end else if (EN) begin
      if (pre == PRE_MAX) begin
        pre_next  = '0;
        tick_next = 1'b1;
        if (!(&TIMESTAMP)) begin
          ts_next = TIMESTAMP + WIDTH'(1);
        end else if (SATURATE == 0) begin
          ts_next   = '0;
          roll_next = 1'b1;
        end
      end else begin
        pre_next = pre + PW'(1);
      end
    end
  end

  assign edges = EVENT & ~event_d;
  assign move  = (!CAP_VALID || CAP_READY) && win_valid;

  always_comb begin
    move_hit = '0;
    for (int c = 0; c < NUM_CH; c++) move_hit[c] = move && (win == CH_W'(c));
  end

  ts_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req       (pend),
    .ptr       (rr_ptr),
    .gnt_valid (win_valid),
    .gnt_idx   (win)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      TIMESTAMP <= '0;
      pre       <= '0;
      TICK      <= 1'b0;
      ROLLOVER  <= 1'b0;
      SAT       <= 1'b0;
      event_d   <= '0;
      pend      <= '0;
      OVF       <= '0;
      CAP_VALID <= 1'b0;
      CAP_CH    <= '0;
      CAP_TS    <= '0;
      rr_ptr    <= CH_W'(NUM_CH - 1);
      for (int c = 0; c < NUM_CH; c++) cap_mem[c] <= '0;
    end else begin
      TIMESTAMP <= ts_next;
      pre       <= pre_next;
      TICK      <= tick_next;
      ROLLOVER  <= roll_next;
      SAT       <= (SATURATE != 0) && (&ts_next);
      event_d   <= EVENT;

      if (move) begin
        CAP_VALID <= 1'b1;
        CAP_CH    <= win;
        CAP_TS    <= cap_mem[win];
        rr_ptr    <= win;
      end else if (CAP_READY) begin
        CAP_VALID <= 1'b0;
      end

      // A slot being emptied this edge may take a fresh capture; otherwise the
      // first captured value is kept and the channel is flagged.
      for (int c = 0; c < NUM_CH; c++) begin
        if (edges[c] && (!pend[c] || move_hit[c])) begin
          cap_mem[c] <= TIMESTAMP;
          pend[c]    <= 1'b1;
        end else if (move_hit[c]) begin
          pend[c] <= 1'b0;
        end
        if (edges[c] && pend[c] && !move_hit[c]) OVF[c] <= 1'b1;
        else if (CLR_OVF[c])                     OVF[c] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_timestamp_capture.sv
// Bench for timestamp_capture: a 24-bit/prescale-3/4-channel instance checked
// against a reference model every cycle, plus two 4-bit instances for wrap/saturate.
module tb_timestamp_capture;

  localparam int W  = 24;
  localparam int N  = 4;
  localparam int PS = 3;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic         en, load, ready;
  logic [W-1:0] lv;
  logic [N-1:0] ev, clr;
  logic [W-1:0] ts, cts;
  logic         tick, roll, sat, cv;
  logic [1:0]   cch;
  logic [N-1:0] ovf;

  logic       sm_en, sm_load;
  logic [3:0] sm_lv;
  logic [3:0] w_ts, w_cts, h_ts, h_cts;
  logic       w_tick, w_roll, w_sat, w_cv, w_ch, w_ovf;
  logic       h_tick, h_roll, h_sat, h_cv, h_ch, h_ovf;

  timestamp_capture #(.WIDTH(W), .PRESCALE(PS), .NUM_CH(N), .SATURATE(0)) dut (
    .CLK(CLK), .RESET(RESET), .EN(en), .LOAD(load), .LOAD_VAL(lv),
    .TIMESTAMP(ts), .TICK(tick), .ROLLOVER(roll), .SAT(sat),
    .EVENT(ev), .CAP_VALID(cv), .CAP_READY(ready), .CAP_CH(cch), .CAP_TS(cts),
    .OVF(ovf), .CLR_OVF(clr)
  );

  timestamp_capture #(.WIDTH(4), .PRESCALE(1), .NUM_CH(1), .SATURATE(0)) dut_wrap (
    .CLK(CLK), .RESET(RESET), .EN(sm_en), .LOAD(sm_load), .LOAD_VAL(sm_lv),
    .TIMESTAMP(w_ts), .TICK(w_tick), .ROLLOVER(w_roll), .SAT(w_sat),
    .EVENT(1'b0), .CAP_VALID(w_cv), .CAP_READY(1'b1), .CAP_CH(w_ch), .CAP_TS(w_cts),
    .OVF(w_ovf), .CLR_OVF(1'b0)
  );

  timestamp_capture #(.WIDTH(4), .PRESCALE(1), .NUM_CH(1), .SATURATE(1)) dut_hold (
    .CLK(CLK), .RESET(RESET), .EN(sm_en), .LOAD(sm_load), .LOAD_VAL(sm_lv),
    .TIMESTAMP(h_ts), .TICK(h_tick), .ROLLOVER(h_roll), .SAT(h_sat),
    .EVENT(1'b0), .CAP_VALID(h_cv), .CAP_READY(1'b1), .CAP_CH(h_ch), .CAP_TS(h_cts),
    .OVF(h_ovf), .CLR_OVF(1'b0)
  );

  int checks, errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the timestamp is base + (enabled cycles since load) / PS,
  // truncated to W bits; captures sit in one slot per channel ahead of a
  // single output register.
  int unsigned  m_cnt;
  logic [W-1:0] m_base;
  logic         m_tick, m_roll;
  logic [N-1:0] m_evd, m_pend, m_ovf;
  logic [W-1:0] m_val [N];
  logic         m_cv;
  logic [1:0]   m_ch, m_rr;
  logic [W-1:0] m_cts;
  logic [W+1:0] exp_q[$];

  function automatic logic [W-1:0] m_ts();
    return m_base + W'(m_cnt / PS);
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_base = '0; m_tick = 0; m_roll = 0;
    m_evd = '0; m_pend = '0; m_ovf = '0;
    for (int c = 0; c < N; c++) m_val[c] = '0;
    m_cv = 0; m_ch = '0; m_cts = '0; m_rr = 2'(N - 1);
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [W-1:0] old_ts;
    logic [N-1:0] edges;
    logic         found;
    int           w;
    old_ts = m_ts();
    edges  = ev & ~m_evd;
    m_evd  = ev;
    found  = 0;
    w      = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && m_pend[(int'(m_rr) + k) % N]) begin
        found = 1;
        w = (int'(m_rr) + k) % N;
      end
    end
    if ((!m_cv || ready) && found) begin
      m_cv = 1; m_ch = 2'(w); m_cts = m_val[w]; m_rr = 2'(w); m_pend[w] = 0;
      exp_q.push_back({m_ch, m_cts});
    end else if (ready) begin
      m_cv = 0;
    end
    for (int c = 0; c < N; c++) begin
      if (edges[c] && m_pend[c]) m_ovf[c] = 1;
      else if (clr[c])           m_ovf[c] = 0;
      if (edges[c] && !m_pend[c]) begin
        m_pend[c] = 1;
        m_val[c]  = old_ts;
      end
    end
    if (load) begin
      m_base = lv; m_cnt = 0; m_tick = 0; m_roll = 0;
    end else if (en) begin
      m_cnt++;
      m_tick = (m_cnt % PS == 0);
      m_roll = m_tick && (m_ts() == '0);
    end else begin
      m_tick = 0; m_roll = 0;
    end
  endtask

  task automatic compare_main();
    chk("ts", ts, m_ts());
    chk("tick", tick, m_tick);
    chk("rollover", roll, m_roll);
    chk("sat", sat, 1'b0);
    chk("cap_valid", cv, m_cv);
    chk("ovf", ovf, m_ovf);
    if (m_cv) begin
      chk("cap_ch", cch, m_ch);
      chk("cap_ts", cts, m_cts);
    end
  endtask

  // One clock: scoreboard any accept, step the model with this cycle's inputs,
  // then compare just after the edge.
  task automatic cycle();
    logic [W+1:0] e;
    if (cv && ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_accept: got ch %0d ts 0x%0h expected no capture", cch, cts);
      end else begin
        e = exp_q.pop_front();
        chk("sb_accept", {cch, cts}, e);
      end
    end
    @(posedge CLK);
    model_step();
    #1;
    compare_main();
  endtask

  typedef struct {
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic [3:0] w_ts;
    logic       w_roll;
    logic       tick;
    logic [3:0] h_ts;
    logic       h_sat;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] t1;
  int           ncap;

  initial begin
    vecs[0] = '{1'b1, 4'd14, 1'b0, 4'd14, 1'b0, 1'b0, 4'd14, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 1'b1};
    vecs[2] = '{1'b0, 4'd0,  1'b1, 4'd0,  1'b1, 1'b1, 4'd15, 1'b1};
    vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd1,  1'b0, 1'b1, 4'd15, 1'b1};
    vecs[4] = '{1'b0, 4'd0,  1'b0, 4'd1,  1'b0, 1'b0, 4'd15, 1'b1};
    vecs[5] = '{1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b1};
    vecs[6] = '{1'b1, 4'd3,  1'b1, 4'd3,  1'b0, 1'b0, 4'd3,  1'b0};
    vecs[7] = '{1'b0, 4'd0,  1'b1, 4'd4,  1'b0, 1'b1, 4'd4,  1'b0};

    checks = 0; errors = 0;
    RESET = 1; en = 0; load = 0; lv = '0; ev = '0; ready = 1; clr = '0;
    sm_en = 0; sm_load = 0; sm_lv = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ts", ts, 0);        chk("rst_tick", tick, 0);   chk("rst_roll", roll, 0);
    chk("rst_cv", cv, 0);        chk("rst_ch", cch, 0);      chk("rst_cts", cts, 0);
    chk("rst_ovf", ovf, 0);      chk("rst_w_ts", w_ts, 0);   chk("rst_h_ts", h_ts, 0);
    chk("rst_h_sat", h_sat, 0);  chk("rst_w_cv", w_cv, 0);   chk("rst_h_cv", h_cv, 0);
    RESET = 0;

    // Prescale by 3 with EN high from reset, then a 2-cycle EN gap.
    en = 1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      chk("ps_ts", ts, W'(i / 3));
      chk("ps_tick", tick, (i % 3 == 0));
    end
    en = 0;
    repeat (2) cycle();
    en = 1;
    cycle(); cycle();
    chk("ps_hold", ts, 3);
    chk("ps_hold_tick", tick, 0);
    cycle();
    chk("ps_delay", ts, 4);
    chk("ps_delay_tick", tick, 1);
    en = 0;

    // 4-bit wrap and saturate instances, table driven.
    for (int i = 0; i < 8; i++) begin
      sm_load = vecs[i].load; sm_lv = vecs[i].lv; sm_en = vecs[i].en;
      cycle();
      chk("w_ts", w_ts, vecs[i].w_ts);
      chk("w_roll", w_roll, vecs[i].w_roll);
      chk("w_tick", w_tick, vecs[i].tick);
      chk("w_sat", w_sat, 0);
      chk("h_ts", h_ts, vecs[i].h_ts);
      chk("h_sat", h_sat, vecs[i].h_sat);
      chk("h_roll", h_roll, 0);
      chk("h_tick", h_tick, vecs[i].tick);
    end
    sm_load = 0; sm_en = 0;

    // Simultaneous events on 0 and 3 with a stalled consumer.
    ready = 0; ev = 4'b1001;
    cycle();
    chk("pair_latency", cv, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("pair_hold_cv", cv, 1);
      chk("pair_hold_ch", cch, 0);
    end
    ready = 1;
    cycle();
    chk("pair_second_cv", cv, 1);
    chk("pair_second_ch", cch, 3);
    cycle();
    chk("pair_drain", cv, 0);
    ev = '0;
    cycle();
    ev = 4'b1001;
    cycle();
    cycle();
    chk("rr_first", cch, 0);
    cycle();
    chk("rr_second", cch, 3);
    ev = '0;
    cycle();

    // Event on channel 2 at the edge where 0x0A increments to 0x0B.
    load = 1; lv = W'(24'h00000A);
    cycle();
    load = 0; en = 1;
    cycle(); cycle();
    ev = 4'b0100;
    cycle();
    chk("inc_edge_ts", ts, 24'h00000B);
    chk("inc_edge_cv", cv, 0);
    en = 0;
    cycle();
    chk("inc_cap_cv", cv, 1);
    chk("inc_cap_ch", cch, 2);
    chk("inc_cap_ts", cts, 24'h00000A);
    chk("inc_cap_now", ts, 24'h00000B);
    ev = '0;
    cycle();

    // Overflow on channel 1 while the output is stalled.
    en = 1; ready = 0; ev = 4'b0001;
    cycle();
    ev = '0;
    cycle();
    t1 = m_ts();
    ev = 4'b0010;
    cycle();
    ev = '0;
    cycle();
    ev = 4'b0010;
    cycle();
    chk("ovf_set", ovf, 4'b0010);
    ev = '0; clr = 4'b0010;
    cycle();
    chk("ovf_clr", ovf, 4'b0000);
    ev = 4'b0010;
    cycle();
    chk("ovf_clr_race", ovf, 4'b0010);
    ev = '0; clr = '0; ready = 1;
    cycle();
    chk("ovf_first_ch", cch, 1);
    chk("ovf_first_ts", cts, t1);
    cycle();
    en = 0;

    // Reset in the middle of a stalled transfer with a channel still pending.
    ready = 0; ev = 4'b0101;
    cycle();
    ev = '0;
    cycle();
    chk("prerst_cv", cv, 1);
    #2;
    RESET = 1;
    #1;
    chk("arst_ts", ts, 0);   chk("arst_cv", cv, 0);   chk("arst_ch", cch, 0);
    chk("arst_cts", cts, 0); chk("arst_ovf", ovf, 0); chk("arst_tick", tick, 0);
    model_reset();
    ev = 4'b0001; ready = 1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("rst_hold_cv", cv, 0);
    RESET = 0;
    ncap = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (cv) ncap++;
    end
    chk("held_line_one_capture", ncap, 1);
    ev = '0;
    cycle();

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 19) == 0);
      lv    = W'($urandom);
      if ($urandom_range(0, 2) == 0) lv = {W{1'b1}} - W'($urandom_range(0, 3));
      ev    = N'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
